// File: rtl/mux4_sched_pkg.sv
// Shared types and defaults for the round-robin 4:1 channel scheduler.
package mux4_sched_pkg;

    localparam int unsigned DW_DEF = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef logic [1:0] idx_t;

endpackage

// File: rtl/mux4.sv
// Plain 4:1 data multiplexer driven by a 2-bit select.
module mux4 #(
    parameter int unsigned DW = 4
) (
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    input  logic [1:0]    sel,
    output logic [DW-1:0] y
);

    // Route the selected source word to the output
    always_comb begin
        y = '0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin winner search over four requests, starting at ptr.
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [3:0] req,
    input  idx_t       ptr,
    output logic       any,
    output idx_t       idx,
    output logic [3:0] onehot
);

    // Unrolled priority search: one fixed priority order per pointer value
    always_comb begin
        any    = |req;
        idx    = 2'd0;
        onehot = 4'b0000;
        case (ptr)
            2'd0: begin
                if      (req[0]) idx = 2'd0;
                else if (req[1]) idx = 2'd1;
                else if (req[2]) idx = 2'd2;
                else if (req[3]) idx = 2'd3;
            end
            2'd1: begin
                if      (req[1]) idx = 2'd1;
                else if (req[2]) idx = 2'd2;
                else if (req[3]) idx = 2'd3;
                else if (req[0]) idx = 2'd0;
            end
            2'd2: begin
                if      (req[2]) idx = 2'd2;
                else if (req[3]) idx = 2'd3;
                else if (req[0]) idx = 2'd0;
                else if (req[1]) idx = 2'd1;
            end
            default: begin
                if      (req[3]) idx = 2'd3;
                else if (req[0]) idx = 2'd0;
                else if (req[1]) idx = 2'd1;
                else if (req[2]) idx = 2'd2;
            end
        endcase
        if (any) begin
            onehot = 4'(4'b0001 << idx);
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one output register between four sources.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_src
);

    state_e        state_q, state_d;
    idx_t          ptr_q, ptr_d;
    idx_t          out_src_q, out_src_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic          pick_any;
    idx_t          pick_idx;
    logic [3:0]    pick_onehot;
    logic          can_load;
    logic          capture;
    logic [DW-1:0] mux_y;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    mux4 #(.DW(DW)) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (sel),
        .y   (mux_y)
    );

    // Load permission: register empty, or full and being drained this cycle
    always_comb begin
        can_load = 1'b0;
        if (!rst) begin
            can_load = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        end
        capture = can_load && pick_any;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fill on capture, empty when drained with nothing new
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (capture) state_d = HOLD;
            HOLD: if (out_ready) state_d = capture ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant and select follow the winner only while capturing
    always_comb begin
        gnt       = 4'b0000;
        sel       = out_src_q;
        out_valid = (state_q == HOLD);
        if (capture) begin
            gnt = pick_onehot;
            sel = pick_idx;
        end
    end

    // Datapath next values: captured word, its source, and the rotated pointer
    always_comb begin
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        ptr_d      = ptr_q;
        if (capture) begin
            out_data_d = mux_y;
            out_src_d  = pick_idx;
            ptr_d      = idx_t'(pick_idx + 2'd1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q <= '0;
            out_src_q  <= 2'd0;
            ptr_q      <= 2'd0;
        end else begin
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched with a scoreboard of expected captured words.
module tb_mux4_rr_sched;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] dv [4];
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];

    logic       m_valid;
    logic [1:0] m_ptr;
    logic [1:0] m_src;

    mux4_rr_sched #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (dv[0]),
        .d1        (dv[1]),
        .d2        (dv[2]),
        .d3        (dv[3]),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 2'd0;
        m_src   = 2'd0;
        sbq.delete();
    endtask

    // One clock cycle: check comb and registered outputs mid-cycle, advance model, cross the edge
    task automatic cyc();
        logic       can;
        logic       cap;
        int         w;
        logic [3:0] eg;
        logic [1:0] esel;
        @(negedge clk);
        can = !m_valid || out_ready;
        w   = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (int'(m_ptr) + k) % 4;
            if (w < 0 && req[i]) w = i;
        end
        cap  = can && (w >= 0);
        eg   = cap ? 4'(1 << w) : 4'b0000;
        esel = cap ? 2'(w) : m_src;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("sel", 32'(sel), 32'(esel));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("sb_depth", 32'(sbq.size()), 32'd1);
            if (sbq.size() > 0) begin
                chk("out_data", 32'(out_data), 32'(sbq[0].data));
                chk("out_src", 32'(out_src), 32'(sbq[0].src));
            end
            if (out_ready && sbq.size() > 0) void'(sbq.pop_front());
        end
        if (cap) begin
            sbq.push_back({2'(w), dv[w]});
            m_ptr   = 2'(w + 1);
            m_src   = 2'(w);
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] g3 [5];
        logic [3:0] d3 [5];
        g3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        d3 = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
        for (int i = 0; i < 4; i++) dv[i] = 4'(i);
        rst       = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_gnt_req", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        req = 4'b0000;
        rst = 1'b0;
        #1;

        // Idle after reset
        repeat (10) cyc();
        chk("idle_data", 32'(out_data), 32'd0);

        // Single request from source 1
        out_ready = 1'b1;
        req = 4'b0010;
        #1;
        chk("single_gnt", 32'(gnt), 32'b0010);
        cyc();
        req = 4'b0000;
        #1;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'd1);
        chk("single_src", 32'(out_src), 32'd1);
        cyc();
        chk("single_drain", 32'(out_valid), 32'd0);

        // Full fairness
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fair_gnt", 32'(gnt), 32'(g3[i]));
            cyc();
            chk("fair_data", 32'(out_data), 32'(d3[i]));
            chk("fair_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure holds everything
        do_reset();
        req = 4'b1111;
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_gnt", 32'(gnt), 32'd0);
            chk("bp_data", 32'(out_data), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(gnt), 32'b0010);
        cyc();
        chk("bp_release_data", 32'(out_data), 32'd1);

        // Pointer skips past the last winner
        do_reset();
        req = 4'b0001;
        cyc();
        req = 4'b1001;
        #1;
        chk("skip_gnt3", 32'(gnt), 32'b1000);
        cyc();
        chk("skip_gnt0", 32'(gnt), 32'b0001);
        cyc();
        chk("skip_gnt3b", 32'(gnt), 32'b1000);
        cyc();

        // Asynchronous reset while holding a word
        out_ready = 1'b0;
        cyc();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_gnt", 32'(gnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        repeat (4) cyc();

        // Random mix against the model
        for (int i = 0; i < 200; i++) begin
            req       = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
Round-robin scheduler that shares one DW-bit output channel between four requesters.
- Each cycle it picks one requester, drives the 4:1 select, and captures the selected word into a one-entry output register.
- The register drains through a valid/ready handshake.
- Sits in front of the mux2/mux4 datapath as the block that sequences its select lines; sustains one word per cycle.

Parameters:
DW, 4, data width of each source word and of out_data.

Ports:
clk  input  1  system clock, single clock domain, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  4  per-source request; req[i] means d<i> holds a word to send
d0  input  DW  source 0 data
d1  input  DW  source 1 data
d2  input  DW  source 2 data
d3  input  DW  source 3 data
gnt  output  4  one-hot accept, combinational; gnt[i]=1 in the cycle d<i> is captured
sel  output  2  mux select; winner index when capturing, else last winner
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  downstream accepts out_data when out_valid=1
out_data  output  DW  captured word
out_src  output  2  index of the source that produced out_data

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_src=0, ptr=0, sel=0, gnt=0.
- Assertion of rst takes effect immediately, without waiting for a clock edge.
- State machine:
  - IDLE: output register empty.
  - HOLD: output register full; out_valid=1.
- can_load = (state==IDLE) or (state==HOLD and out_ready).
- Winner selection:
  - Search req starting at index ptr, ascending, wrapping 3->0.
  - The first set bit wins.
  - Implemented as an unrolled 4-case search; no modular arithmetic on widths wider than 2 bits.
- Capture: when can_load and |req:
  - gnt[winner]=1 that cycle; sel=winner.
  - At the clock edge: out_data<=d[winner], out_src<=winner, ptr<=winner+1 (2-bit wrap), state<=HOLD.
- Latency: req seen in cycle k -> gnt in cycle k -> out_valid/out_data valid in cycle k+1.
- State transitions:
  - IDLE, no req -> stay IDLE.
  - HOLD, out_ready=1, no req -> IDLE; out_valid=0 next cycle.
  - HOLD, out_ready=1, req present -> transfer and new capture in the same cycle; stays HOLD. Full throughput, no bubble.
  - HOLD, out_ready=0 -> gnt=0; out_data, out_src, ptr and sel are all held stable.
- When not capturing, sel=out_src.
- No request memory: req[i] dropped before being granted is forgotten, never granted.
- Requesters must hold d<i> stable while req[i]=1 and gnt[i]=0.
- Reset mid-operation:
  - The held word is discarded; out_valid drops immediately.
  - ptr returns to 0, so the first grant after reset goes to the lowest set req.
- out_ready while out_valid=0 is ignored.
- Simultaneous req bits: exactly one gnt bit is high, never more.

Decomposition:
- Package mux4_sched_pkg:
  - DW default.
  - State enum (IDLE=0, HOLD=1).
  - Index type (2-bit).
- Sub-module rr_pick4: combinational, inputs req[3:0] and ptr[1:0], outputs any, idx[1:0], onehot[3:0].
- Data selection reuses the existing 4:1 mux block, driven by sel.

Test Plan:
1. Idle after reset: rst pulse, req=0000 for 10 cycles -> out_valid=0, gnt=0000, sel=00, out_data=0000 throughout.
2. Single request: d0..d3 = 0000/0001/0010/0011, req=0010 for one cycle at cycle k, out_ready=1 -> gnt=0010 at k; out_valid=1, out_data=0001, out_src=01 at k+1; out_valid=0 at k+2.
3. Full fairness: req=1111 held, out_ready=1 -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; out_data 0000,0001,0010,0011,0000 one cycle later; out_valid stays 1.
4. Backpressure: req=1111, out_ready=0 after first capture (src 0) -> gnt=0000 and out_data=0000 stable for 5 cycles; out_ready=1 -> next gnt=0010, out_data=0001 the following cycle.
5. Pointer skip: after a grant to source 0, req=1001 -> gnt=1000 next, then 0001; never 0001 twice in a row.
6. Async reset mid-HOLD: out_valid=1, rst asserted between clock edges -> out_valid=0 before the next edge. After release with req=1111 -> first gnt=0001.
